// File: rtl/alu_exec_stage_if.sv
// rtl/alu_exec_stage_if.sv - micro-op, alu8 and result signals of the execute stage
interface alu_exec_stage_if;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_op;
   logic        in_wide;
   logic [15:0] in_a;
   logic [15:0] in_b;
   logic [7:0]  alu_a;
   logic [7:0]  alu_b;
   logic [4:0]  alu_op;
   logic        alu_cin;
   logic [7:0]  alu_res;
   logic [7:0]  alu_flags;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_res;
   logic        out_wr;
   logic [7:0]  f_reg;
   logic        f_wr;
   logic [7:0]  f_wdata;

   modport slave (
      input  in_valid, in_op, in_wide, in_a, in_b, alu_res, alu_flags,
             out_ready, f_wr, f_wdata,
      output in_ready, alu_a, alu_b, alu_op, alu_cin, out_valid, out_res,
             out_wr, f_reg
   );

   modport master (
      output in_valid, in_op, in_wide, in_a, in_b, alu_res, alu_flags,
             out_ready, f_wr, f_wdata,
      input  in_ready, alu_a, alu_b, alu_op, alu_cin, out_valid, out_res,
             out_wr, f_reg
   );
endinterface

// File: rtl/alu_exec_stage.sv
// rtl/alu_exec_stage.sv - execute-stage sequencer driving alu8, owning the F register
module alu_exec_stage #(
   parameter logic [7:0] F_RESET = 8'h00
) (
   input logic               clk,
   input logic               rst,
   alu_exec_stage_if.slave   bus
);
   localparam logic [4:0] OP_ADD  = 5'b00000;
   localparam logic [4:0] OP_ADC  = 5'b00001;
   localparam logic [4:0] OP_SBC  = 5'b00011;
   localparam logic [4:0] OP_CP   = 5'b00100;
   localparam logic [4:0] OP_RL   = 5'b01000;
   localparam logic [4:0] OP_RR   = 5'b01001;
   localparam logic [4:0] OP_RLA  = 5'b01010;
   localparam logic [4:0] OP_RRA  = 5'b01011;
   localparam logic [4:0] OP_RLCA = 5'b01110;
   localparam logic [4:0] OP_RRCA = 5'b01111;
   localparam logic [4:0] OP_LAST = 5'b10010;

   typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

   state_t      state;
   state_t      state_nxt;
   logic [4:0]  op_r;
   logic        wide_r;
   logic [15:0] a_r;
   logic [15:0] b_r;
   logic [7:0]  res_lo;
   logic        carry_lo;
   logic [15:0] out_res_r;
   logic        out_wr_r;
   logic [7:0]  f_r;

   logic uses_cin;
   logic acc_rot;
   logic op_defined;
   logic op_is_cp;
   logic unused_bits;

   assign uses_cin   = op_r inside {OP_ADC, OP_SBC, OP_RL, OP_RR, OP_RLA, OP_RRA};
   assign acc_rot    = op_r inside {OP_RLA, OP_RRA, OP_RLCA, OP_RRCA};
   assign op_defined = (op_r <= OP_LAST);
   assign op_is_cp   = (op_r == OP_CP);

   assign unused_bits = &{1'b0, bus.alu_flags[3:0], bus.f_wdata[3:0]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.in_valid) state_nxt = LO;
         LO:      state_nxt = wide_r ? HI : DONE;
         HI:      state_nxt = DONE;
         DONE:    if (bus.out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.alu_a     = 8'h00;
      bus.alu_b     = 8'h00;
      bus.alu_op    = 5'b00000;
      bus.alu_cin   = 1'b0;
      case (state)
         IDLE: bus.in_ready = 1'b1;
         LO: begin
            bus.alu_a   = a_r[7:0];
            bus.alu_b   = b_r[7:0];
            bus.alu_op  = wide_r ? OP_ADD : op_r;
            bus.alu_cin = !wide_r && uses_cin && f_r[4];
         end
         HI: begin
            bus.alu_a   = a_r[15:8];
            bus.alu_b   = b_r[15:8];
            bus.alu_op  = OP_ADC;
            bus.alu_cin = carry_lo;
         end
         DONE: bus.out_valid = 1'b1;
         default: ;
      endcase
   end

   assign bus.out_res = out_res_r;
   assign bus.out_wr  = out_wr_r;
   assign bus.f_reg   = f_r;

   // F load precedes the accept so a same-cycle op already sees the loaded carry
   always_ff @(posedge clk) begin
      if (rst) begin
         op_r      <= 5'b00000;
         wide_r    <= 1'b0;
         a_r       <= 16'h0000;
         b_r       <= 16'h0000;
         res_lo    <= 8'h00;
         carry_lo  <= 1'b0;
         out_res_r <= 16'h0000;
         out_wr_r  <= 1'b0;
         f_r       <= F_RESET & 8'hF0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.f_wr) f_r <= bus.f_wdata & 8'hF0;
               if (bus.in_valid) begin
                  op_r   <= bus.in_op;
                  wide_r <= bus.in_wide;
                  a_r    <= bus.in_a;
                  b_r    <= bus.in_b;
               end
            end
            LO: begin
               res_lo   <= bus.alu_res;
               carry_lo <= bus.alu_flags[4];
               if (!wide_r) begin
                  if (!op_defined) begin
                     out_res_r <= {8'h00, a_r[7:0]};
                     out_wr_r  <= 1'b0;
                  end else begin
                     out_res_r <= {8'h00, op_is_cp ? a_r[7:0] : bus.alu_res};
                     out_wr_r  <= !op_is_cp;
                     f_r       <= {bus.alu_flags[7] && !acc_rot, bus.alu_flags[6:4], 4'h0};
                  end
               end
            end
            HI: begin
               out_res_r <= {bus.alu_res, res_lo};
               out_wr_r  <= 1'b1;
               f_r       <= {f_r[7], 1'b0, bus.alu_flags[5:4], 4'h0};
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_exec_stage.sv
// tb/tb_alu_exec_stage.sv - directed and random checks of alu_exec_stage against a reference model
module tb_alu_exec_stage;
   logic clk = 1'b0;
   logic rst = 1'b1;

   alu_exec_stage_if bus();

   alu_exec_stage #(.F_RESET(8'h00)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int          n_assert = 0;
   int          n_fail   = 0;
   logic [7:0]  model_f;
   logic [7:0]  lo_a, lo_b, hi_a, hi_b;
   logic [4:0]  lo_op, hi_op;
   logic        lo_cin, hi_cin;
   int          lat;

   // alu8 stand-in; low flag nibble is deliberately non-zero
   function automatic logic [15:0] alu_fn(input logic [4:0] op, input logic [7:0] a,
                                          input logic [7:0] b, input logic cin);
      int ia, ib, ic, s, hs, r;
      logic n, h, c;
      ia = int'(a); ib = int'(b); ic = int'(cin);
      n = 1'b0; h = 1'b0; c = 1'b0; r = 0;
      case (op)
         5'd0, 5'd1: begin
            if (op == 5'd0) ic = 0;
            s = ia + ib + ic; hs = ia % 16 + ib % 16 + ic;
            r = s % 256; h = hs > 15; c = s > 255;
         end
         5'd2, 5'd3, 5'd4: begin
            if (op != 5'd3) ic = 0;
            s = ia - ib - ic; hs = ia % 16 - ib % 16 - ic;
            r = (s + 256) % 256; n = 1'b1; h = hs < 0; c = s < 0;
         end
         5'd5: begin r = ia & ib; h = 1'b1; end
         5'd6: r = ia | ib;
         5'd7: r = ia ^ ib;
         5'd8, 5'd10:  begin r = (ia * 2 + ic) % 256;         c = ia >= 128; end
         5'd9, 5'd11:  begin r = ia / 2 + ic * 128;           c = ia % 2 == 1; end
         5'd12, 5'd14: begin r = (ia * 2) % 256 + ia / 128;   c = ia >= 128; end
         5'd13, 5'd15: begin r = ia / 2 + (ia % 2) * 128;     c = ia % 2 == 1; end
         5'd16: begin r = (ia * 2) % 256;                     c = ia >= 128; end
         5'd17: begin r = ia / 2 + (ia / 128) * 128;          c = ia % 2 == 1; end
         5'd18: begin r = ia / 2;                             c = ia % 2 == 1; end
         default: return 16'hFAEE;
      endcase
      return {r == 0, n, h, c, 4'hA, r[7:0]};
   endfunction

   always_comb {bus.alu_flags, bus.alu_res} = alu_fn(bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_cin);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic ref_op(input logic [4:0] op, input logic w, input logic [15:0] a,
                         input logic [15:0] b, output logic [15:0] er, output logic er_wr,
                         output logic [7:0] ef);
      int sum, hsum;
      logic cin;
      logic [15:0] t;
      if (w) begin
         sum  = int'(a) + int'(b);
         hsum = int'(a[11:0]) + int'(b[11:0]);
         er = sum[15:0]; er_wr = 1'b1;
         ef = {model_f[7], 1'b0, hsum >= 4096, sum >= 65536, 4'h0};
      end else if (op > 5'd18) begin
         er = {8'h00, a[7:0]}; er_wr = 1'b0; ef = model_f;
      end else begin
         cin = (op inside {5'd1, 5'd3, 5'd8, 5'd9, 5'd10, 5'd11}) ? model_f[4] : 1'b0;
         t  = alu_fn(op, a[7:0], b[7:0], cin);
         ef = t[15:8] & 8'hF0;
         if (op inside {5'd10, 5'd11, 5'd14, 5'd15}) ef[7] = 1'b0;
         er    = (op == 5'd4) ? {8'h00, a[7:0]} : {8'h00, t[7:0]};
         er_wr = (op != 5'd4);
      end
   endtask

   // Offers one op, follows it to DONE and leaves it held (out_ready low)
   task automatic do_op(input logic [4:0] op, input logic w, input logic [15:0] a,
                        input logic [15:0] b, input logic fw, input logic [7:0] fd);
      logic [15:0] er;
      logic        er_wr;
      logic [7:0]  ef;
      logic        exp_cin;
      bus.in_valid = 1'b1; bus.in_op = op; bus.in_wide = w;
      bus.in_a = a; bus.in_b = b; bus.f_wr = fw; bus.f_wdata = fd;
      chk("in_ready_idle", bus.in_ready, 1);
      if (fw) model_f = fd & 8'hF0;
      exp_cin = (!w && (op inside {5'd1, 5'd3, 5'd8, 5'd9, 5'd10, 5'd11})) ? model_f[4] : 1'b0;
      ref_op(op, w, a, b, er, er_wr, ef);
      @(posedge clk); #1;
      bus.in_valid = 1'b0; bus.f_wr = 1'b0;
      lat = 1;
      lo_a = bus.alu_a; lo_b = bus.alu_b; lo_op = bus.alu_op; lo_cin = bus.alu_cin;
      while (bus.out_valid !== 1'b1 && lat < 8) begin
         @(posedge clk); #1;
         lat++;
         if (lat == 2) begin
            hi_a = bus.alu_a; hi_b = bus.alu_b; hi_op = bus.alu_op; hi_cin = bus.alu_cin;
         end
      end
      chk("latency", lat, w ? 3 : 2);
      chk("lo_alu_a", lo_a, a[7:0]);
      chk("lo_alu_b", lo_b, b[7:0]);
      chk("lo_alu_op", lo_op, w ? 5'd0 : op);
      chk("lo_alu_cin", lo_cin, exp_cin);
      if (w) begin
         chk("hi_alu_a", hi_a, a[15:8]);
         chk("hi_alu_b", hi_b, b[15:8]);
         chk("hi_alu_op", hi_op, 5'd1);
         chk("hi_alu_cin", hi_cin, (int'(a[7:0]) + int'(b[7:0])) >= 256);
      end
      chk("out_res", bus.out_res, er);
      chk("out_wr", bus.out_wr, er_wr);
      chk("f_reg", bus.f_reg, ef);
      model_f = ef;
   endtask

   task automatic release_out();
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      chk("rel_out_valid", bus.out_valid, 0);
      chk("rel_in_ready", bus.in_ready, 1);
   endtask

   initial begin
      logic [15:0] held_res;
      bus.in_valid = 1'b0; bus.in_op = 5'd0; bus.in_wide = 1'b0;
      bus.in_a = 16'h0; bus.in_b = 16'h0; bus.out_ready = 1'b0;
      bus.f_wr = 1'b0; bus.f_wdata = 8'h00;
      model_f = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_res", bus.out_res, 0);
      chk("rst_out_wr", bus.out_wr, 0);
      chk("rst_f_reg", bus.f_reg, 8'h00);
      chk("rst_alu", {bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_cin}, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      do_op(5'd0, 1'b0, 16'h003A, 16'h00C6, 1'b0, 8'h00);
      chk("add_cin", lo_cin, 0);
      chk("add_res", bus.out_res, 16'h0000);
      chk("add_wr", bus.out_wr, 1);
      chk("add_f", bus.f_reg, 8'hB0);
      chk("add_lat", lat, 2);
      release_out();

      do_op(5'd1, 1'b0, 16'h0010, 16'h0001, 1'b0, 8'h00);
      chk("adc_cin", lo_cin, 1);
      chk("adc_res", bus.out_res, 16'h0012);
      chk("adc_f", bus.f_reg, 8'h00);
      release_out();

      do_op(5'd7, 1'b1, 16'h0FFF, 16'h0001, 1'b1, 8'h80);
      chk("wide_lo_op", lo_op, 5'd0);
      chk("wide_hi_op", hi_op, 5'd1);
      chk("wide_hi_cin", hi_cin, 1);
      chk("wide_res", bus.out_res, 16'h1000);
      chk("wide_f", bus.f_reg, 8'hA0);
      chk("wide_lat", lat, 3);
      release_out();

      do_op(5'd4, 1'b0, 16'h0042, 16'h0042, 1'b0, 8'h00);
      chk("cp_wr", bus.out_wr, 0);
      chk("cp_res", bus.out_res, 16'h0042);
      chk("cp_f", bus.f_reg, 8'hC0);
      release_out();
      do_op(5'd14, 1'b0, 16'h0000, 16'h0000, 1'b0, 8'h00);
      chk("rlca_f", bus.f_reg, 8'h00);
      release_out();
      do_op(5'd12, 1'b0, 16'h0000, 16'h0000, 1'b0, 8'h00);
      chk("rlc_f", bus.f_reg, 8'h80);

      held_res = bus.out_res;
      for (int i = 0; i < 5; i++) begin
         bus.f_wr = 1'b1; bus.f_wdata = 8'hFF;
         @(posedge clk); #1;
         chk("bp_out_valid", bus.out_valid, 1);
         chk("bp_out_res", bus.out_res, held_res);
         chk("bp_f_reg", bus.f_reg, 8'h80);
         chk("bp_in_ready", bus.in_ready, 0);
      end
      bus.f_wr = 1'b0;
      release_out();
      bus.f_wr = 1'b1; bus.f_wdata = 8'hFF;
      @(posedge clk); #1;
      bus.f_wr = 1'b0;
      chk("fload_f", bus.f_reg, 8'hF0);
      model_f = 8'hF0;

      do_op(5'h1F, 1'b0, 16'h1234, 16'h5678, 1'b0, 8'h00);
      chk("undef_wr", bus.out_wr, 0);
      chk("undef_res", bus.out_res, 16'h0034);
      chk("undef_f", bus.f_reg, 8'hF0);
      release_out();

      for (int i = 0; i < 60; i++) begin
         do_op(5'($urandom_range(0, 31)), $urandom_range(0, 3) == 0, 16'($urandom),
               16'($urandom), $urandom_range(0, 4) == 0, 8'($urandom));
         release_out();
      end

      bus.in_valid = 1'b1; bus.in_wide = 1'b1; bus.in_a = 16'h8123; bus.in_b = 16'h9456;
      bus.f_wr = 1'b1; bus.f_wdata = 8'hF0;
      @(posedge clk); #1;
      bus.in_valid = 1'b0; bus.f_wr = 1'b0;
      @(posedge clk); #1;
      chk("abort_in_hi", bus.alu_op, 5'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_out_valid", bus.out_valid, 0);
      chk("abort_in_ready", bus.in_ready, 1);
      chk("abort_f_reg", bus.f_reg, 8'h00);
      model_f = 8'h00;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         chk("abort_no_result", bus.out_valid, 0);
      end

      do_op(5'd2, 1'b0, 16'h0010, 16'h0020, 1'b0, 8'h00);
      release_out();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
